// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave port: FSM encoding, default
// parameters and the SCLK leading/trailing edge mapping.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ACTIVE     = 2'd1,
      ST_WAIT_DESEL = 2'd2
   } slave_state_t;

   localparam int DEF_PACKET_SIZE = 8;
   localparam bit DEF_MISO_IDLE   = 1'b1;
   localparam bit DEF_CPOL        = 1'b0;
   localparam bit DEF_CPHA        = 1'b0;
   localparam int SYNC_STAGES     = 3;

   // Returns {leading, trailing}; leading is SCLK leaving its idle level.
   function automatic logic [1:0] edge_pair(input logic cpol, input logic rise,
                                            input logic fall);
      return cpol ? {fall, rise} : {rise, fall};
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer plus a history flop for one asynchronous pin;
// level, rise and fall all appear three clk after the pin changes.
module spi_input_sync
   import spi_slave_pkg::*;
#(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] pipe;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe <= {SYNC_STAGES{RST_VAL}};
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         pipe <= {pipe[SYNC_STAGES-2:0], din};
         rise <= pipe[SYNC_STAGES-2] & ~pipe[SYNC_STAGES-1];
         fall <= ~pipe[SYNC_STAGES-2] & pipe[SYNC_STAGES-1];
      end
   end

   assign level = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave port: oversampled SCLK/MOSI/CS_N, MSB-first receive register
// and a single-entry TX holding register returned on MISO.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   ST_IDLE       | deselected, waiting for CS_N to fall
//   ST_ACTIVE     | frame in progress, shifting packets
//   ST_WAIT_DESEL | left reset with CS_N low; ignore SCLK until CS_N high
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int SPI_PACKET_SIZE = DEF_PACKET_SIZE,
   parameter bit SPI_MISO_IDLE   = DEF_MISO_IDLE,
   parameter bit SPI_CPOL        = DEF_CPOL,
   parameter bit SPI_CPHA        = DEF_CPHA
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       spi_clk,
   input  logic                       spi_mosi,
   input  logic                       spi_cs_n,
   output logic                       spi_miso,
   input  logic [SPI_PACKET_SIZE-1:0] data_tx,
   input  logic                       tx_load,
   output logic                       tx_ready,
   output logic [SPI_PACKET_SIZE-1:0] data_rx,
   output logic                       rx_valid,
   output logic                       busy,
   output logic                       frame_err,
   output logic                       tx_underrun
);

   localparam int CW = (SPI_PACKET_SIZE > 2) ? $clog2(SPI_PACKET_SIZE) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(SPI_PACKET_SIZE - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [SPI_PACKET_SIZE-1:0] IDLE_WORD = {SPI_PACKET_SIZE{SPI_MISO_IDLE}};

   slave_state_t               state;
   logic [CW-1:0]              bit_cnt;
   logic [SPI_PACKET_SIZE-1:0] tx_shift;
   logic [SPI_PACKET_SIZE-1:0] tx_hold;
   logic [SPI_PACKET_SIZE-1:0] rx_shift;
   logic [SPI_PACKET_SIZE-1:0] rx_next;
   logic [SPI_PACKET_SIZE-1:0] next_word;
   logic                       sampled;
   logic                       miso_en;

   logic sclk_rise, sclk_fall, unused_sclk_level;
   logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic lead_edge, trail_edge, sample_edge, shift_edge;
   logic pkt_start, word_done, take;

   spi_input_sync #(.RST_VAL(SPI_CPOL)) u_sync_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_clk),
      .level (unused_sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_input_sync #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_mosi),
      .level (mosi_lvl),
      .rise  (unused_mosi_rise),
      .fall  (unused_mosi_fall)
   );

   // Resets to "selected" so a CS_N held low through reset never looks
   // like a fresh falling edge; a high CS_N shows up only as a rise.
   spi_input_sync #(.RST_VAL(1'b0)) u_sync_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_cs_n),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   assign {lead_edge, trail_edge} = edge_pair(SPI_CPOL, sclk_rise, sclk_fall);
   assign sample_edge = SPI_CPHA ? trail_edge : lead_edge;
   assign shift_edge  = SPI_CPHA ? lead_edge  : trail_edge;

   assign pkt_start = (state == ST_IDLE) && cs_fall;
   assign word_done = (state == ST_ACTIVE) && !cs_rise && sample_edge && (bit_cnt == '0);
   assign take      = pkt_start || word_done;
   assign next_word = tx_ready ? IDLE_WORD : tx_hold;

   always_comb begin
      rx_next          = rx_shift;
      rx_next[bit_cnt] = mosi_lvl;
   end

   // Tracks the synchronized CS_N level so it moves 3 clk after the pin.
   assign busy = !cs_lvl && (state != ST_WAIT_DESEL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_WAIT_DESEL;
         bit_cnt     <= LAST_BIT;
         tx_shift    <= IDLE_WORD;
         tx_hold     <= '0;
         tx_ready    <= 1'b1;
         rx_shift    <= '0;
         data_rx     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
         spi_miso    <= SPI_MISO_IDLE;
         sampled     <= 1'b0;
         miso_en     <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= take && tx_ready;

         if (tx_load && tx_ready) begin
            tx_hold  <= data_tx;
            tx_ready <= 1'b0;
         end else if (take) begin
            tx_ready <= 1'b1;
         end

         case (state)
            ST_WAIT_DESEL: begin
               if (cs_lvl) state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (cs_fall) begin
                  state    <= ST_ACTIVE;
                  bit_cnt  <= LAST_BIT;
                  tx_shift <= next_word;
                  sampled  <= 1'b0;
                  miso_en  <= !SPI_CPHA;
                  spi_miso <= SPI_CPHA ? SPI_MISO_IDLE : next_word[SPI_PACKET_SIZE-1];
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  spi_miso  <= SPI_MISO_IDLE;
                  miso_en   <= 1'b0;
                  frame_err <= (bit_cnt != LAST_BIT) || sampled;
               end else if (sample_edge) begin
                  rx_shift <= rx_next;
                  if (bit_cnt == '0) begin
                     data_rx  <= rx_next;
                     rx_valid <= 1'b1;
                     bit_cnt  <= LAST_BIT;
                     tx_shift <= next_word;
                     sampled  <= 1'b0;
                     spi_miso <= miso_en ? next_word[SPI_PACKET_SIZE-1] : SPI_MISO_IDLE;
                  end else begin
                     sampled <= 1'b1;
                  end
               end else if (shift_edge) begin
                  // A shift edge with no sample yet belongs to the packet
                  // boundary (or the CPHA=1 MISO enable), never a decrement.
                  if (sampled) begin
                     bit_cnt  <= bit_cnt - ONE;
                     spi_miso <= tx_shift[bit_cnt - ONE];
                  end else if (!miso_en) begin
                     miso_en  <= 1'b1;
                     spi_miso <= tx_shift[bit_cnt];
                  end
               end
            end
            default: state <= ST_WAIT_DESEL;
         endcase
      end
   end

endmodule
